// File: rtl/lbp_pkg.sv
// Shared types and helpers for the streaming LBP engine: FSM states,
// neighbour bit positions in the code, and the raster address function.
package lbp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_FETCH,
        ST_CALC,
        ST_BORDER,
        ST_DONE
    } lbp_state_e;

    localparam int NB_TL = 0;
    localparam int NB_T  = 1;
    localparam int NB_TR = 2;
    localparam int NB_L  = 3;
    localparam int NB_R  = 4;
    localparam int NB_BL = 5;
    localparam int NB_B  = 6;
    localparam int NB_BR = 7;

    function automatic int pix_addr(input int row, input int col, input int width);
        return row * width + col;
    endfunction

endpackage

// File: rtl/lbp_window.sv
// 3x3 sliding window: two stored columns plus the column being fetched, and
// the 8-neighbour comparator tree evaluated as the last pixel arrives.
module lbp_window
    import lbp_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          shift_en,
    input  logic [1:0]    row_sel,
    input  logic [DW-1:0] din,
    input  logic [DW-1:0] th,
    output logic [7:0]    code
);

    logic [DW-1:0] left_q  [3];
    logic [DW-1:0] left_d  [3];
    logic [DW-1:0] mid_q   [3];
    logic [DW-1:0] mid_d   [3];
    logic [DW-1:0] right_q [2];
    logic [DW-1:0] right_d [2];

    // Sum kept one bit wider so centre + th can never wrap.
    function automatic logic nb_set(input logic [DW-1:0] nb, input logic [DW-1:0] ctr,
                                    input logic [DW-1:0] t);
        return {1'b0, nb} >= ({1'b0, ctr} + {1'b0, t});
    endfunction

    always_comb begin
        left_d  = left_q;
        mid_d   = mid_q;
        right_d = right_q;
        if (shift_en) begin
            if (row_sel == 2'd2) begin
                left_d   = mid_q;
                mid_d[0] = right_q[0];
                mid_d[1] = right_q[1];
                mid_d[2] = din;
            end else begin
                right_d[row_sel[0]] = din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            left_q  <= '{default: '0};
            mid_q   <= '{default: '0};
            right_q <= '{default: '0};
        end else begin
            left_q  <= left_d;
            mid_q   <= mid_d;
            right_q <= right_d;
        end
    end

    // The bottom-right neighbour is the live read data, so the code is valid
    // in the cycle the third row of the right column returns.
    always_comb begin
        code        = '0;
        code[NB_TL] = nb_set(left_q[0],  mid_q[1], th);
        code[NB_T]  = nb_set(mid_q[0],   mid_q[1], th);
        code[NB_TR] = nb_set(right_q[0], mid_q[1], th);
        code[NB_L]  = nb_set(left_q[1],  mid_q[1], th);
        code[NB_R]  = nb_set(right_q[1], mid_q[1], th);
        code[NB_BL] = nb_set(left_q[2],  mid_q[1], th);
        code[NB_B]  = nb_set(mid_q[2],   mid_q[1], th);
        code[NB_BR] = nb_set(din,        mid_q[1], th);
    end

endmodule

// File: rtl/lbp_stream.sv
// Streaming LBP engine: reads a grey image column by column through a sliding
// 3x3 window and writes one 8-bit code per interior pixel (optionally zeros on the border).
module lbp_stream
    import lbp_pkg::*;
#(
    parameter int IMG_W       = 128,
    parameter int IMG_H       = 128,
    parameter int DW          = 8,
    parameter int AW          = 14,
    parameter int BORDER_ZERO = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          gray_ready,
    input  logic [DW-1:0] lbp_th,
    output logic [AW-1:0] gray_addr,
    output logic          gray_req,
    input  logic [DW-1:0] gray_data,
    output logic [AW-1:0] lbp_addr,
    output logic          lbp_valid,
    output logic [7:0]    lbp_data,
    output logic          finish
);

    localparam logic [AW-1:0] ONE      = AW'(1);
    localparam logic [AW-1:0] COL_LAST = AW'(IMG_W - 2);
    localparam logic [AW-1:0] ROW_LAST = AW'(IMG_H - 2);
    localparam logic [AW-1:0] W_MAX    = AW'(IMG_W - 1);
    localparam logic [AW-1:0] H_MAX    = AW'(IMG_H - 1);

    lbp_state_e    state_q, state_d;
    logic [2:0]    idx_q, idx_d, nidx;
    logic [AW-1:0] row_q, row_d, col_q, col_d;
    logic [DW-1:0] th_q, th_d;
    logic          gray_req_q, gray_req_d;
    logic [AW-1:0] gray_addr_q, gray_addr_d;
    logic          lbp_valid_q, lbp_valid_d;
    logic [AW-1:0] lbp_addr_q, lbp_addr_d;
    logic [7:0]    lbp_data_q, lbp_data_d;
    logic          finish_q, finish_d;
    logic          rd_vld_q, rd_vld_d;
    logic [1:0]    rd_row_q, rd_row_d;
    logic [7:0]    code;

    function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] row, input logic [AW-1:0] col);
        return AW'(pix_addr(int'(row), int'(col), IMG_W));
    endfunction

    // Prime order is column 0 rows 0..2, then column 1 rows 0..2.
    function automatic logic [1:0] prime_row(input logic [2:0] idx);
        return (idx < 3'd3) ? idx[1:0] : 2'(idx - 3'd3);
    endfunction

    function automatic logic [AW-1:0] prime_col(input logic [2:0] idx);
        return (idx < 3'd3) ? '0 : ONE;
    endfunction

    lbp_window #(.DW(DW)) u_window (
        .clk     (clk),
        .reset   (reset),
        .shift_en(rd_vld_q),
        .row_sel (rd_row_q),
        .din     (gray_data),
        .th      (th_q),
        .code    (code)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        nidx        = idx_q + 3'd1;
        row_d       = row_q;
        col_d       = col_q;
        th_d        = th_q;
        gray_req_d  = 1'b0;
        gray_addr_d = gray_addr_q;
        lbp_valid_d = 1'b0;
        lbp_addr_d  = lbp_addr_q;
        lbp_data_d  = lbp_data_q;
        finish_d    = finish_q;
        rd_vld_d    = gray_req_q;
        rd_row_d    = 2'd0;

        case (state_q)
            ST_PRIME: rd_row_d = prime_row(idx_q);
            ST_FETCH: rd_row_d = idx_q[1:0];
            default:  rd_row_d = 2'd0;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (gray_ready) begin
                    th_d        = lbp_th;
                    row_d       = ONE;
                    col_d       = ONE;
                    idx_d       = '0;
                    state_d     = ST_PRIME;
                    gray_req_d  = 1'b1;
                    gray_addr_d = '0;
                end
            end
            ST_PRIME: begin
                gray_req_d = 1'b1;
                if (idx_q != 3'd5) begin
                    idx_d       = nidx;
                    gray_addr_d = addr_of(row_q - ONE + AW'(prime_row(nidx)),
                                          col_q - ONE + prime_col(nidx));
                end else begin
                    idx_d       = '0;
                    state_d     = ST_FETCH;
                    gray_addr_d = addr_of(row_q - ONE, col_q + ONE);
                end
            end
            ST_FETCH: begin
                if (idx_q != 3'd2) begin
                    gray_req_d  = 1'b1;
                    idx_d       = nidx;
                    gray_addr_d = addr_of(row_q - ONE + AW'(nidx[1:0]), col_q + ONE);
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                lbp_valid_d = 1'b1;
                lbp_data_d  = code;
                lbp_addr_d  = addr_of(row_q, col_q);
                idx_d       = '0;
                if (col_q < COL_LAST) begin
                    col_d       = col_q + ONE;
                    state_d     = ST_FETCH;
                    gray_req_d  = 1'b1;
                    gray_addr_d = addr_of(row_q - ONE, col_q + AW'(2));
                end else if (row_q < ROW_LAST) begin
                    row_d       = row_q + ONE;
                    col_d       = ONE;
                    state_d     = ST_PRIME;
                    gray_req_d  = 1'b1;
                    gray_addr_d = addr_of(row_q, '0);
                end else if (BORDER_ZERO != 0) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = ST_BORDER;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_BORDER: begin
                // Raster walk of the frame: full top/bottom rows, two ends elsewhere.
                lbp_valid_d = 1'b1;
                lbp_data_d  = '0;
                lbp_addr_d  = addr_of(row_q, col_q);
                if (row_q == H_MAX && col_q == W_MAX) begin
                    state_d = ST_DONE;
                end else if (col_q == W_MAX) begin
                    row_d = row_q + ONE;
                    col_d = '0;
                end else if (row_q == '0 || row_q == H_MAX) begin
                    col_d = col_q + ONE;
                end else begin
                    col_d = W_MAX;
                end
            end
            ST_DONE: begin
                finish_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            th_q        <= '0;
            gray_req_q  <= 1'b0;
            gray_addr_q <= '0;
            lbp_valid_q <= 1'b0;
            lbp_addr_q  <= '0;
            lbp_data_q  <= '0;
            finish_q    <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_row_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            row_q       <= row_d;
            col_q       <= col_d;
            th_q        <= th_d;
            gray_req_q  <= gray_req_d;
            gray_addr_q <= gray_addr_d;
            lbp_valid_q <= lbp_valid_d;
            lbp_addr_q  <= lbp_addr_d;
            lbp_data_q  <= lbp_data_d;
            finish_q    <= finish_d;
            rd_vld_q    <= rd_vld_d;
            rd_row_q    <= rd_row_d;
        end
    end

    assign gray_addr = gray_addr_q;
    assign gray_req  = gray_req_q;
    assign lbp_addr  = lbp_addr_q;
    assign lbp_valid = lbp_valid_q;
    assign lbp_data  = lbp_data_q;
    assign finish    = finish_q;

endmodule

// File: tb/tb_lbp_stream.sv
// Directed bench for lbp_stream: four configurations (4x4, 3x3, 4x4 with border
// zeroing, 8x8 with 10-bit pixels) each backed by a synchronous RAM model.
module tb_lbp_stream;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rdy = '0;
    logic [7:0] th8 = '0;
    logic [9:0] th10 = '0;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: 4x4, no border writes
    logic [3:0] a_gaddr, a_laddr;
    logic       a_req, a_lv, a_fin;
    logic [7:0] a_gdata, a_ld;
    logic [7:0] mem_a [16];
    // Instance B: 3x3
    logic [3:0] b_gaddr, b_laddr;
    logic       b_req, b_lv, b_fin;
    logic [7:0] b_gdata, b_ld;
    logic [7:0] mem_b [16];
    // Instance C: 4x4 with border zeroing
    logic [3:0] c_gaddr, c_laddr;
    logic       c_req, c_lv, c_fin;
    logic [7:0] c_gdata, c_ld;
    logic [7:0] mem_c [16];
    // Instance D: 8x8, 10-bit pixels, AW=6
    logic [5:0] d_gaddr, d_laddr;
    logic       d_req, d_lv, d_fin;
    logic [9:0] d_gdata;
    logic [7:0] d_ld;
    logic [9:0] mem_d [64];

    lbp_stream #(.IMG_W(4), .IMG_H(4), .DW(8), .AW(4), .BORDER_ZERO(0)) u_a (
        .clk(clk), .reset(reset), .gray_ready(rdy[0]), .lbp_th(th8),
        .gray_addr(a_gaddr), .gray_req(a_req), .gray_data(a_gdata),
        .lbp_addr(a_laddr), .lbp_valid(a_lv), .lbp_data(a_ld), .finish(a_fin));

    lbp_stream #(.IMG_W(3), .IMG_H(3), .DW(8), .AW(4), .BORDER_ZERO(0)) u_b (
        .clk(clk), .reset(reset), .gray_ready(rdy[1]), .lbp_th(th8),
        .gray_addr(b_gaddr), .gray_req(b_req), .gray_data(b_gdata),
        .lbp_addr(b_laddr), .lbp_valid(b_lv), .lbp_data(b_ld), .finish(b_fin));

    lbp_stream #(.IMG_W(4), .IMG_H(4), .DW(8), .AW(4), .BORDER_ZERO(1)) u_c (
        .clk(clk), .reset(reset), .gray_ready(rdy[2]), .lbp_th(th8),
        .gray_addr(c_gaddr), .gray_req(c_req), .gray_data(c_gdata),
        .lbp_addr(c_laddr), .lbp_valid(c_lv), .lbp_data(c_ld), .finish(c_fin));

    lbp_stream #(.IMG_W(8), .IMG_H(8), .DW(10), .AW(6), .BORDER_ZERO(0)) u_d (
        .clk(clk), .reset(reset), .gray_ready(rdy[3]), .lbp_th(th10),
        .gray_addr(d_gaddr), .gray_req(d_req), .gray_data(d_gdata),
        .lbp_addr(d_laddr), .lbp_valid(d_lv), .lbp_data(d_ld), .finish(d_fin));

    // Synchronous RAMs: data valid the cycle after the request
    always @(posedge clk) if (a_req) a_gdata <= mem_a[a_gaddr];
    always @(posedge clk) if (b_req) b_gdata <= mem_b[b_gaddr];
    always @(posedge clk) if (c_req) c_gdata <= mem_c[c_gaddr];
    always @(posedge clk) if (d_req) d_gdata <= mem_d[d_gaddr];

    // Selected instance for the write monitor
    int         sel = 0;
    logic       m_valid, m_req, m_fin;
    int         m_addr;
    logic [7:0] m_data;

    always_comb begin
        m_valid = 1'b0; m_req = 1'b0; m_fin = 1'b0; m_addr = 0; m_data = '0;
        case (sel)
            0: begin m_valid = a_lv; m_req = a_req; m_fin = a_fin; m_addr = int'(a_laddr); m_data = a_ld; end
            1: begin m_valid = b_lv; m_req = b_req; m_fin = b_fin; m_addr = int'(b_laddr); m_data = b_ld; end
            2: begin m_valid = c_lv; m_req = c_req; m_fin = c_fin; m_addr = int'(c_laddr); m_data = c_ld; end
            default: begin m_valid = d_lv; m_req = d_req; m_fin = d_fin; m_addr = int'(d_laddr); m_data = d_ld; end
        endcase
    end

    logic       clr = 1'b0;
    int         cap_n, first_req, first_vld, last_vld, fin_cyc;
    int         cap_addr [64];
    logic [7:0] cap_data [64];

    always @(negedge clk) begin
        if (clr) begin
            cap_n <= 0; first_req <= -1; first_vld <= -1; last_vld <= -1; fin_cyc <= -1;
        end else begin
            if (m_req && first_req < 0) first_req <= cyc;
            if (m_valid) begin
                if (cap_n < 64) begin
                    cap_addr[cap_n] <= m_addr;
                    cap_data[cap_n] <= m_data;
                end
                if (first_vld < 0) first_vld <= cyc;
                last_vld <= cyc;
                cap_n    <= cap_n + 1;
            end
            if (m_fin && fin_cyc < 0) fin_cyc <= cyc;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int exp_int [4]  = '{5, 6, 9, 10};
    int exp_c   [16] = '{5, 6, 9, 10, 0, 1, 2, 3, 4, 7, 8, 11, 12, 13, 14, 15};

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic start_run(input int which);
        sel = which;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        rdy[which] = 1'b1;
        @(posedge clk); #1;
        rdy[which] = 1'b0;
    endtask

    task automatic wait_finish(input string tag, input int bound);
        int k = 0;
        while (!m_fin && k < bound) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_finish"}, int'(m_fin), 1);
        @(negedge clk); #1;
    endtask

    task automatic check_interior(input string tag, input int exp_data);
        chk({tag, "_count"}, cap_n, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), cap_addr[i], exp_int[i]);
            chk($sformatf("%s_data%0d", tag, i), int'(cap_data[i]), exp_data);
        end
    endtask

    initial begin
        int k;
        int data_or;
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 8'd50;
            mem_b[i] = 8'd101;
            mem_c[i] = 8'(i * 10);
        end
        mem_b[4] = 8'd100;
        mem_b[0] = 8'd99;
        for (int i = 0; i < 64; i++) mem_d[i] = 10'd1023;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_gray_addr", int'(a_gaddr), 0);
        chk("rst_gray_req",  int'(a_req),   0);
        chk("rst_lbp_valid", int'(a_lv),    0);
        chk("rst_finish",    int'(a_fin),   0);
        reset = 1'b0;

        // 4x4 flat image, th=0; threshold changed after start must be ignored
        th8 = 8'd0;
        start_run(0);
        th8 = 8'd1;
        wait_finish("flat_th0", 500);
        check_interior("flat_th0", 8'hFF);
        chk("flat_th0_finish_lag", fin_cyc - last_vld, 1);
        rdy[0] = 1'b1;
        @(posedge clk); #1;
        rdy[0] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("done_ignore_count", cap_n, 4);
        chk("done_ignore_req",   int'(a_req), 0);
        chk("done_sticky_fin",   int'(a_fin), 1);

        // Same image, th=1
        do_reset();
        th8 = 8'd1;
        start_run(0);
        wait_finish("flat_th1", 500);
        check_interior("flat_th1", 8'h00);

        // Reset in the middle of row 2, then a clean rerun
        do_reset();
        th8 = 8'd0;
        start_run(0);
        k = 0;
        while (cap_n < 3 && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        chk("midrst_reached_row2", int'(cap_n >= 3), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_gray_addr", int'(a_gaddr), 0);
        chk("midrst_gray_req",  int'(a_req),   0);
        chk("midrst_lbp_addr",  int'(a_laddr), 0);
        chk("midrst_lbp_valid", int'(a_lv),    0);
        chk("midrst_lbp_data",  int'(a_ld),    0);
        chk("midrst_finish",    int'(a_fin),   0);
        reset = 1'b0;
        start_run(0);
        wait_finish("rerun", 500);
        check_interior("rerun", 8'hFF);

        // 3x3: single code, latency from the IDLE exit edge
        do_reset();
        th8 = 8'd0;
        start_run(1);
        wait_finish("img3", 500);
        chk("img3_count", cap_n, 1);
        chk("img3_addr", cap_addr[0], 4);
        chk("img3_data", int'(cap_data[0]), 8'hFE);
        chk("img3_latency", first_vld - first_req + 1, 11);

        // 4x4 gradient with border zeroing
        do_reset();
        th8 = 8'd0;
        start_run(2);
        wait_finish("border", 500);
        chk("border_count", cap_n, 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("border_addr%0d", i), cap_addr[i], exp_c[i]);
            chk($sformatf("border_data%0d", i), int'(cap_data[i]), (i < 4) ? 8'hF0 : 0);
        end

        // 8x8, 10-bit full-scale pixels and threshold
        do_reset();
        th10 = 10'd1023;
        start_run(3);
        wait_finish("wide", 3000);
        chk("wide_count", cap_n, 36);
        chk("wide_first_addr", cap_addr[0], 9);
        chk("wide_last_addr", cap_addr[35], 54);
        data_or = 0;
        for (int i = 0; i < 36; i++) data_or = data_or | int'(cap_data[i]);
        chk("wide_data_or", data_or, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
